// File: rtl/fpu_control_word_port.sv
// -----------------------------------------------------------------------------
// fpu_control_word_port
//
// CPU-to-FPU control word write port (I/O ports 0xF8-0xF9). Byte or word CPU
// writes are merged into the architectural control word. The x87 reserved-bit
// rules are then applied, and each update is handed to the FPU over a
// valid/ready handshake. A CPU write that arrives while the FPU has not yet
// taken the previous update is stalled until the handshake completes.
//
// Ports:
//   clk, reset            system clock, synchronous active-low reset
//   cs                    chip select from the I/O address decoder
//   data_m_wr_en          1 = write access, 0 = read access
//   data_m_bytesel[1:0]   byte enables ([0] -> bits 7:0, [1] -> bits 15:8)
//   data_m_data_in[15:0]  CPU write data
//   data_m_data_out[15:0] CPU read data
//   data_m_ack            single-cycle access acknowledge
//   fpu_init              FINIT/FNINIT pulse from the FPU
//   cw_out[15:0]          control word presented to the FPU
//   cw_valid              an update is pending for the FPU
//   cw_ready              FPU accepts the pending update
//
// Build option:
//   FPU_CW_READBACK_EN    when defined, reads return the control word. When
//                         undefined, reads are still acked but return 16'hFFFF.
// -----------------------------------------------------------------------------
module fpu_control_word_port #(
  parameter logic [15:0] RESET_CW = 16'h037F,
  parameter logic [15:0] WR_MASK  = 16'h1F3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic [15:0] data_m_data_in,
  output logic [15:0] data_m_data_out,
  output logic        data_m_ack,
  input  logic        fpu_init,
  output logic [15:0] cw_out,
  output logic        cw_valid,
  input  logic        cw_ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACK   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] cw_q, cw_d;
  logic        pending_q, pending_d;
  logic        ack_q, ack_d;
  logic        write_en;
  logic [15:0] merged;
  logic [15:0] stored;

  // Unselected bytes keep their current value. Bit 6 is forced to 1. Bits
  // outside WR_MASK (15:13 and 7) are forced to 0.
  assign merged = {data_m_bytesel[1] ? data_m_data_in[15:8] : cw_q[15:8],
                   data_m_bytesel[0] ? data_m_data_in[7:0]  : cw_q[7:0]};
  assign stored = (merged & WR_MASK) | 16'h0040;

  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would infer a latch.
    state_d   = state_q;
    cw_d      = cw_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    write_en  = 1'b0;

    // Handshake completes on the edge where ready is sampled with valid high.
    if (pending_q && cw_ready) pending_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs && !ack_q) begin
          if (!data_m_wr_en) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
          end else if (fpu_init) begin
            // fpu_init wins the cycle. The write stays in IDLE and retries next cycle.
            state_d = ST_IDLE;
          end else if (pending_q) begin
            state_d = ST_STALL;
          end else begin
            write_en = 1'b1;
            state_d  = ST_ACK;
            ack_d    = 1'b1;
          end
        end
      end
      ST_ACK: state_d = ST_IDLE;
      ST_STALL: begin
        // When cs is dropped, the write is abandoned. When pending has cleared,
        // the write is re-evaluated from IDLE on the next cycle, which is
        // where it is performed.
        if (!cs || !pending_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (write_en) begin
      cw_d = stored;
      if (data_m_bytesel != 2'b00) pending_d = 1'b1;
    end

    // The FPU already holds the default word after FINIT, so no update is sent.
    if (fpu_init) begin
      cw_d      = RESET_CW;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so that all flops
    // update together from values sampled before the edge.
    if (!reset) begin
      state_q   <= ST_IDLE;
      cw_q      <= RESET_CW;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cw_q      <= cw_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
    end
  end

  assign cw_out     = cw_q;
  assign cw_valid   = pending_q;
  assign data_m_ack = ack_q;

`ifdef FPU_CW_READBACK_EN
  assign data_m_data_out = cw_q;
`else
  assign data_m_data_out = 16'hFFFF;
`endif

endmodule

// File: tb/tb_fpu_control_word_port.sv
module tb_fpu_control_word_port;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic        data_m_ack;
  logic        fpu_init;
  logic [15:0] cw_out;
  logic        cw_valid;
  logic        cw_ready;

  int total = 0;
  int bad   = 0;

  fpu_control_word_port dut (
    .clk             (clk),
    .reset           (reset),
    .cs              (cs),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_bytesel  (data_m_bytesel),
    .data_m_data_in  (data_m_data_in),
    .data_m_data_out (data_m_data_out),
    .data_m_ack      (data_m_ack),
    .fpu_init        (fpu_init),
    .cw_out          (cw_out),
    .cw_valid        (cw_valid),
    .cw_ready        (cw_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data expected from a control word, depending on the build option.
  function automatic logic [15:0] rd_exp(input logic [15:0] cw);
`ifdef FPU_CW_READBACK_EN
    return cw;
`else
    return 16'hFFFF;
`endif
  endfunction

  // Advance one edge. Inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one access and wait (bounded) for ack. lat = edges to ack, -1 = none.
  // Returns 1ns after the ack edge, with cs already dropped.
  task automatic access(input logic wr, input logic [1:0] bsel,
                        input logic [15:0] data, output int lat);
    cs = 1'b1; data_m_wr_en = wr; data_m_bytesel = bsel; data_m_data_in = data;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (data_m_ack === 1'b1) begin lat = i; break; end
    end
    cs = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cs = 1'b0; data_m_wr_en = 1'b0; data_m_bytesel = 2'b00;
    data_m_data_in = 16'h0000; fpu_init = 1'b0; cw_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    total++; if (cw_out !== 16'h037F) begin bad++; $display("FAIL reset_cw got=%h exp=%h", cw_out, 16'h037F); end
    total++; if (cw_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", cw_valid); end
    total++; if (data_m_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", data_m_ack); end
  endtask

  task automatic test_read();
    int lat;
    access(1'b0, 2'b11, 16'h0000, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL read_lat got=%0d exp=1", lat); end
    total++; if (data_m_data_out !== rd_exp(16'h037F)) begin bad++; $display("FAIL read_data got=%h exp=%h", data_m_data_out, rd_exp(16'h037F)); end
    total++; if (cw_valid !== 1'b0) begin bad++; $display("FAIL read_valid got=%b exp=0", cw_valid); end
    tick();
    total++; if (data_m_ack !== 1'b0) begin bad++; $display("FAIL read_ack_one_cycle got=%b exp=0", data_m_ack); end
  endtask

  task automatic test_word_write();
    int lat;
    cw_ready = 1'b1;
    access(1'b1, 2'b11, 16'hFFFF, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL ww_lat got=%0d exp=1", lat); end
    total++; if (cw_out !== 16'h1F7F) begin bad++; $display("FAIL ww_cw got=%h exp=%h", cw_out, 16'h1F7F); end
    total++; if (cw_valid !== 1'b1) begin bad++; $display("FAIL ww_valid_high got=%b exp=1", cw_valid); end
    tick();
    total++; if (cw_valid !== 1'b0) begin bad++; $display("FAIL ww_valid_pulse got=%b exp=0", cw_valid); end
    total++; if (data_m_ack !== 1'b0) begin bad++; $display("FAIL ww_ack_drop got=%b exp=0", data_m_ack); end
  endtask

  task automatic test_stall();
    int lat;
    cw_ready = 1'b0;
    access(1'b1, 2'b11, 16'h0C7F, lat);
    total++; if (lat !== 1 || cw_out !== 16'h0C7F) begin bad++; $display("FAIL st_first got lat=%0d cw=%h exp lat=1 cw=0c7f", lat, cw_out); end
    tick();
    cs = 1'b1; data_m_wr_en = 1'b1; data_m_bytesel = 2'b11; data_m_data_in = 16'h027F;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (data_m_ack !== 1'b0 || cw_out !== 16'h0C7F || cw_valid !== 1'b1) begin
        bad++; $display("FAIL st_hold%0d got ack=%b cw=%h v=%b exp ack=0 cw=0c7f v=1", i, data_m_ack, cw_out, cw_valid);
      end
    end
    cw_ready = 1'b1;
    tick();  // handshake edge
    cw_ready = 1'b0;
    total++; if (cw_valid !== 1'b0 || data_m_ack !== 1'b0) begin bad++; $display("FAIL st_hs got v=%b ack=%b exp v=0 ack=0", cw_valid, data_m_ack); end
    tick();
    total++; if (data_m_ack !== 1'b0 || cw_out !== 16'h0C7F) begin bad++; $display("FAIL st_wait got ack=%b cw=%h exp ack=0 cw=0c7f", data_m_ack, cw_out); end
    tick();
    cs = 1'b0;
    total++; if (data_m_ack !== 1'b1) begin bad++; $display("FAIL st_ack got=%b exp=1", data_m_ack); end
    total++; if (cw_out !== 16'h027F) begin bad++; $display("FAIL st_cw got=%h exp=%h", cw_out, 16'h027F); end
    total++; if (cw_valid !== 1'b1) begin bad++; $display("FAIL st_revalid got=%b exp=1", cw_valid); end
    cw_ready = 1'b1;
    tick();
    total++; if (cw_valid !== 1'b0 || data_m_ack !== 1'b0) begin bad++; $display("FAIL st_done got v=%b ack=%b exp 0 0", cw_valid, data_m_ack); end
  endtask

  task automatic test_byte_write();
    int lat;
    fpu_init = 1'b1;
    tick();
    fpu_init = 1'b0;
    total++; if (cw_out !== 16'h037F || cw_valid !== 1'b0) begin bad++; $display("FAIL bw_init got cw=%h v=%b exp 037f 0", cw_out, cw_valid); end
    cw_ready = 1'b1;
    access(1'b1, 2'b10, 16'h0800, lat);
    total++; if (lat !== 1 || cw_out !== 16'h087F) begin bad++; $display("FAIL bw_high got lat=%0d cw=%h exp 1 087f", lat, cw_out); end
    tick();
    access(1'b1, 2'b00, 16'h1234, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL bw_none_lat got=%0d exp=1", lat); end
    total++; if (cw_out !== 16'h087F || cw_valid !== 1'b0) begin bad++; $display("FAIL bw_none got cw=%h v=%b exp 087f 0", cw_out, cw_valid); end
    tick();
    access(1'b1, 2'b01, 16'h00AA, lat);
    total++; if (lat !== 1 || cw_out !== 16'h086A) begin bad++; $display("FAIL bw_low got lat=%0d cw=%h exp 1 086a", lat, cw_out); end
    tick();
    access(1'b0, 2'b11, 16'h0000, lat);
    total++; if (lat !== 1 || data_m_data_out !== rd_exp(16'h086A)) begin bad++; $display("FAIL bw_read got lat=%0d d=%h exp 1 %h", lat, data_m_data_out, rd_exp(16'h086A)); end
    tick();
  endtask

  task automatic test_init_collision();
    int lat;
    cw_ready = 1'b1;
    cs = 1'b1; data_m_wr_en = 1'b1; data_m_bytesel = 2'b11; data_m_data_in = 16'h0000;
    fpu_init = 1'b1;
    tick();
    fpu_init = 1'b0;
    total++; if (data_m_ack !== 1'b0 || cw_out !== 16'h037F) begin bad++; $display("FAIL ic_block got ack=%b cw=%h exp 0 037f", data_m_ack, cw_out); end
    tick();
    cs = 1'b0;
    total++; if (data_m_ack !== 1'b1 || cw_out !== 16'h0040 || cw_valid !== 1'b1) begin bad++; $display("FAIL ic_retry got ack=%b cw=%h v=%b exp 1 0040 1", data_m_ack, cw_out, cw_valid); end
    tick();
    fpu_init = 1'b1;
    access(1'b0, 2'b11, 16'h0000, lat);
    fpu_init = 1'b0;
    total++; if (lat !== 1 || data_m_data_out !== rd_exp(16'h037F)) begin bad++; $display("FAIL ic_read got lat=%0d d=%h exp 1 %h", lat, data_m_data_out, rd_exp(16'h037F)); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] din [3];
    logic [15:0] exp [3];
    int k;
    din[0] = 16'h0001; din[1] = 16'h1234; din[2] = 16'hE0BF;
    exp[0] = 16'h0041; exp[1] = 16'h1274; exp[2] = 16'h007F;
    cw_ready = 1'b1;
    k = 0;
    cs = 1'b1; data_m_wr_en = 1'b1; data_m_bytesel = 2'b11; data_m_data_in = din[0];
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++;
      if (data_m_ack !== logic'(i % 2)) begin
        bad++; $display("FAIL b2b_ack%0d got=%b exp=%b", i, data_m_ack, logic'(i % 2));
      end
      if (data_m_ack === 1'b1 && k < 3) begin
        total++;
        if (cw_out !== exp[k]) begin bad++; $display("FAIL b2b_cw%0d got=%h exp=%h", k, cw_out, exp[k]); end
        k++;
        if (k < 3) data_m_data_in = din[k];
      end
    end
    cs = 1'b0;
    tick();
  endtask

  task automatic test_reset_stall();
    int lat;
    cw_ready = 1'b0;
    access(1'b1, 2'b11, 16'h0C7F, lat);
    tick();
    cs = 1'b1; data_m_wr_en = 1'b1; data_m_bytesel = 2'b11; data_m_data_in = 16'h027F;
    tick(); tick();
    total++; if (cw_valid !== 1'b1 || data_m_ack !== 1'b0) begin bad++; $display("FAIL rs_stalled got v=%b ack=%b exp 1 0", cw_valid, data_m_ack); end
    reset = 1'b0;
    tick();
    total++; if (cw_valid !== 1'b0 || data_m_ack !== 1'b0 || cw_out !== 16'h037F) begin bad++; $display("FAIL rs_reset got v=%b ack=%b cw=%h exp 0 0 037f", cw_valid, data_m_ack, cw_out); end
    cs = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_word_write();
    test_stall();
    test_byte_write();
    test_init_collision();
    test_back_to_back();
    test_reset_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_control_word_port.md
# fpu_control_word_port

CPU-to-FPU control word write port at I/O ports 0xF8–0xF9. It accepts byte- or word-wide CPU writes, then applies the x87 reserved-bit rules. The result is stored as the architectural control word. Each update is delivered to the FPU over a valid/ready handshake, and CPU writes stall while the FPU has not yet accepted the previous update. It is the write-direction counterpart of the status word read port at 0xFC–0xFF and sits between the I/O address decoder and the FPU core.

## Interface
Parameters:
- RESET_CW, 16'h037F, control word value after reset and after `fpu_init`
- WR_MASK, 16'h1F3F, bits the CPU can write; all others are forced

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cs  in  1  chip select from the address decoder (ports 0xF8–0xF9)
- data_m_wr_en  in  1  1 = write access, 0 = read access
- data_m_bytesel  in  2  byte enables: [0] selects bits 7:0, [1] selects bits 15:8
- data_m_data_in  in  16  write data from the CPU
- data_m_data_out  out  16  read data to the CPU
- data_m_ack  out  1  single-cycle access acknowledge
- fpu_init  in  1  FINIT/FNINIT pulse from the FPU
- cw_out  out  16  control word presented to the FPU
- cw_valid  out  1  update pending for the FPU
- cw_ready  in  1  FPU accepts the update

## Operation
- Registers:
  - `cw_reg`, the architectural word; `cw_out` = `cw_reg`.
  - `pending`, drives `cw_valid`.
  - `data_m_ack`.
- Write merge rule: merged = bytesel-selected bytes from `data_m_data_in`, other bytes taken from `cw_reg`.
- Stored value = (merged & WR_MASK) | 16'h0040. Bit 6 always reads 1; bits 15:13 and bit 7 always read 0.
- FSM states:
  - IDLE: `cs` low, or previous access completed.
  - ACK: `data_m_ack` high for one cycle.
  - STALL: write requested while `pending`=1.
- Accept condition: an access is accepted when `cs`=1, `data_m_ack`=0 and the cycle is not blocked.
  - Accepted read → ACK.
  - Accepted write with `pending`=0 → update `cw_reg`, set `pending` if bytesel≠00, → ACK.
  - Write with `pending`=1 → STALL.
- STALL: wait until `pending` clears (`cw_valid`&&`cw_ready`), then perform the write on the next cycle → ACK.
- ACK → IDLE unconditionally. The master drops `cs` or starts a new access from IDLE.
- FPU handshake:
  - `cw_valid` holds and `cw_out` stays stable until `cw_ready`=1 is sampled; `pending` clears on the next edge.
  - `cw_ready` while `cw_valid`=0 is ignored.
- `fpu_init`:
  - Sets `cw_reg`=RESET_CW and clears `pending`, since the FPU already holds the default.
  - Has priority over a write in the same cycle; that write is not accepted that cycle and is retried from IDLE/STALL.
  - Does not affect a read.
- `cs` dropped during STALL abandons the write: no ack, `cw_reg` unchanged.
- bytesel=00 write: acked, `cw_reg` and `pending` unchanged.

## Timing
- Reset (`reset`=0 at an edge): `cw_reg`=RESET_CW, `cw_out`=16'h037F, `cw_valid`=0, `data_m_ack`=0, FSM=IDLE. Reset mid-stall or mid-handshake discards all state.
- Read latency: `data_m_ack` one cycle after `cs` is sampled; `data_m_data_out` valid in the ack cycle.
- Unstalled write latency: one cycle. `cw_reg`, `cw_valid` and `data_m_ack` all change on the same edge.
- Stalled write: ack arrives 2 cycles after the `cw_valid`&&`cw_ready` edge.
- `data_m_ack` is never high for two consecutive cycles.
- Maximum update throughput: one control word every 2 cycles when `cw_ready` is tied high.

## Configuration
- FPU_CW_READBACK_EN defined: reads return `cw_reg` on `data_m_data_out`.
- FPU_CW_READBACK_EN undefined: reads are still acked, but `data_m_data_out` = 16'hFFFF constantly. Removes the read mux; write behaviour is identical.

## Test plan
- Release reset, read 0xF8 → ack after 1 cycle; data = 16'h037F (readback enabled) or 16'hFFFF (disabled); `cw_valid`=0.
- Word write 16'hFFFF with `cw_ready`=1 → `cw_out`=16'h1F7F, `cw_valid` pulses 1 cycle, ack after 1 cycle.
- Hold `cw_ready`=0 and write 16'h0C7F, then write 16'h027F → second write gets no ack. Raise `cw_ready` → `cw_out` becomes 16'h027F, ack arrives 2 cycles later, and `cw_valid` re-asserts.
- Write bytesel=10, data 16'h0800, over 16'h037F → `cw_out`=16'h087F; bytesel=00 → acked, no `cw_valid`.
- `fpu_init` in the same cycle as a write of 16'h0000 → `cw_reg`=16'h037F that cycle. The write is accepted the next cycle → 16'h0040.
- Assert `reset`=0 during STALL with `cw_valid`=1 → next cycle `cw_valid`=0, ack=0, `cw_out`=16'h037F.
